// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle unsigned multiply/divide controller (MULTU/DIVU).
// Borrows the shared 32-bit ALU for one ADD or SUB per cycle over 32
// iterations. Owns the HI/LO result registers. Shifts, carry/borrow
// detection and iteration counting are done here.
module mdu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero,
    output logic        alu_own,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result
);

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] wh;
    logic [31:0] wl;
    logic [31:0] m;
    logic [4:0]  cnt;
    logic        op_div;

    logic [31:0] rs;
    logic        msb;
    logic        carry;
    logic        take;
    logic [31:0] wh_next;
    logic [31:0] wl_next;

    // One iteration step: drive the ALU operands from registered state and
    // fold the ALU result back into the next working register values.
    // The shifted remainder of a divide is 33 bits wide; its top bit (msb)
    // forces a subtract because the true remainder then exceeds any divisor.
    always_comb begin
        rs       = {wh[30:0], wl[31]};
        msb      = wh[31];
        carry    = (alu_result < wh);
        take     = msb | !(alu_result > rs);
        alu_a    = 32'd0;
        alu_b    = 32'd0;
        alu_ctrl = ALU_ADD;
        wh_next  = wh;
        wl_next  = wl;
        if (state == RUN) begin
            if (op_div) begin
                alu_a    = rs;
                alu_b    = m;
                alu_ctrl = ALU_SUB;
                wh_next  = take ? alu_result : rs;
                wl_next  = {wl[30:0], take};
            end else begin
                alu_a    = wh;
                alu_b    = wl[0] ? m : 32'd0;
                wh_next  = {carry, alu_result[31:1]};
                wl_next  = {alu_result[0], wl[31:1]};
            end
        end
    end

    // Control FSM with registered status outputs, working registers and
    // the architectural HI/LO result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            alu_own     <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            wh          <= 32'd0;
            wl          <= 32'd0;
            m           <= 32'd0;
            cnt         <= 5'd0;
            op_div      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m           <= src_b;
                        cnt         <= 5'd0;
                        op_div      <= op;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        if (op && (src_b == 32'd0)) begin
                            hi          <= src_a;
                            lo          <= 32'hFFFF_FFFF;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            wh      <= 32'd0;
                            wl      <= src_a;
                            alu_own <= 1'b1;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    wh <= wh_next;
                    wl <= wl_next;
                    if (cnt == 5'd31) begin
                        hi      <= wh_next;
                        lo      <= wl_next;
                        alu_own <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    alu_own <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl with a behavioural
// ADD/SUB ALU standing in for the core's shared ALU.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;
    logic        alu_own;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;

    int checks = 0;
    int passes = 0;

    logic [31:0] prev_hi = 32'd0;
    logic [31:0] prev_lo = 32'd0;

    mdu_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .div_by_zero(div_by_zero),
        .alu_own    (alu_own),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result)
    );

    // Shared ALU model: only ADD and SUB are used by the MDU.
    assign alu_result = (alu_ctrl == 4'b0110) ? (alu_a - alu_b) : (alu_a + alu_b);

    // Free-running clock.
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and tally it.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation in the current (idle) cycle 0 and watch cycles
    // 1..33, optionally pulsing a junk start in cycles ign1/ign2. Returns
    // in cycle 34 with start low.
    task automatic applyStimulus(input string name, input logic o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp_hi,
                                 input logic [31:0] exp_lo, input int ign1, input int ign2);
        logic dbz;
        int   own_bad, busy_bad, ctrl_bad, hold_bad, done_cnt, done_cyc;
        logic [31:0] got_hi, got_lo, got_dbz;
        logic [3:0]  exp_ctrl;
        logic        exp_own, exp_busy;
        dbz = o && (b == 32'd0);
        own_bad = 0; busy_bad = 0; ctrl_bad = 0; hold_bad = 0;
        done_cnt = 0; done_cyc = -1;
        got_hi = 32'hDEAD_BEEF; got_lo = 32'hDEAD_BEEF; got_dbz = 32'hDEAD_BEEF;
        start = 1'b1; op = o; src_a = a; src_b = b;
        for (int k = 1; k <= 33; k++) begin
            step();
            if (k == ign1 || k == ign2) begin
                start = 1'b1; op = ~o; src_a = 32'd99; src_b = 32'd0;
            end else begin
                start = 1'b0;
            end
            exp_own  = !dbz && (k <= 32);
            exp_busy = dbz ? (k == 1) : 1'b1;
            exp_ctrl = (exp_own && o) ? 4'b0110 : 4'b0010;
            if (alu_own !== exp_own) own_bad++;
            if (busy !== exp_busy) busy_bad++;
            if (alu_ctrl !== exp_ctrl) ctrl_bad++;
            if (!dbz && k <= 32 && (hi !== prev_hi || lo !== prev_lo)) hold_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = k;
                got_hi = hi; got_lo = lo; got_dbz = {31'd0, div_by_zero};
            end
        end
        step();
        start = 1'b0;
        checkOutput({name, " own"}, own_bad, 0);
        checkOutput({name, " busy"}, busy_bad, 0);
        checkOutput({name, " ctrl"}, ctrl_bad, 0);
        checkOutput({name, " hold"}, hold_bad, 0);
        checkOutput({name, " done_cnt"}, done_cnt, 1);
        checkOutput({name, " done_cyc"}, done_cyc, dbz ? 1 : 33);
        checkOutput({name, " hi"}, got_hi, exp_hi);
        checkOutput({name, " lo"}, got_lo, exp_lo);
        checkOutput({name, " dbz"}, got_dbz, {31'd0, dbz});
        checkOutput({name, " idle34"}, {31'd0, busy}, 0);
        checkOutput({name, " dbz_held"}, {31'd0, div_by_zero}, {31'd0, dbz});
        prev_hi = exp_hi;
        prev_lo = exp_lo;
    endtask

    // Main directed sequence.
    initial begin
        int dn;
        rst = 1'b1; start = 1'b0; op = 1'b0; src_a = 32'd0; src_b = 32'd0;
        step();
        step();
        rst = 1'b0;

        checkOutput("rst busy", {31'd0, busy}, 0);
        checkOutput("rst done", {31'd0, done}, 0);
        checkOutput("rst hi", hi, 0);
        checkOutput("rst lo", lo, 0);
        checkOutput("rst dbz", {31'd0, div_by_zero}, 0);
        checkOutput("rst own", {31'd0, alu_own}, 0);
        checkOutput("rst alu_a", alu_a, 0);
        checkOutput("rst alu_b", alu_b, 0);
        checkOutput("rst ctrl", {28'd0, alu_ctrl}, 32'h2);

        applyStimulus("mul7x6", 1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 0, 0);
        applyStimulus("mulFFxFF", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
        applyStimulus("div100/7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0);
        applyStimulus("divFF/80", 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 0, 0);
        applyStimulus("div55/0", 1'b1, 32'd55, 32'd0, 32'd55, 32'hFFFF_FFFF, 0, 0);
        applyStimulus("mul3x4ign", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 5, 33);
        applyStimulus("mul7x6b", 1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 0, 0);

        // Reset in cycle 10 of a DIVU 100/7.
        start = 1'b1; op = 1'b1; src_a = 32'd100; src_b = 32'd7;
        for (int k = 1; k <= 10; k++) begin
            step();
            start = 1'b0;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("midrst busy", {31'd0, busy}, 0);
        checkOutput("midrst hi", hi, 0);
        checkOutput("midrst lo", lo, 0);
        checkOutput("midrst own", {31'd0, alu_own}, 0);
        dn = 0;
        for (int k = 0; k < 30; k++) begin
            if (done === 1'b1) dn++;
            step();
        end
        checkOutput("midrst no_done", dn, 0);
        prev_hi = 32'd0;
        prev_lo = 32'd0;

        // Reset and start together: request is dropped.
        rst = 1'b1; start = 1'b1; op = 1'b0; src_a = 32'd5; src_b = 32'd5;
        step();
        rst = 1'b0; start = 1'b0;
        checkOutput("rst+start busy", {31'd0, busy}, 0);
        step();
        checkOutput("rst+start busy2", {31'd0, busy}, 0);

        applyStimulus("mul2x3", 1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
